buf_fill_ctrl: RTL

BUF_FILL_CTRL -- requirements
Module: buf_fill_ctrl

---
 rtl/buf_fill_pkg.sv | 18 +
 rtl/buf_fill_mem.sv | 44 ++++
 rtl/buf_fill_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/buf_fill_pkg.sv
// ----------------------------------------------------------------------------
// buf_fill_pkg
// Shared definitions for the buffer fill/drain controller:
//   - DEPTH_DEF / WIDTH_DEF : default buffer entry count and entry width
//   - state_e               : controller states (IDLE, FILL, DRAIN)
// ----------------------------------------------------------------------------
package buf_fill_pkg;

   localparam int DEPTH_DEF = 8;
   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/buf_fill_mem.sv
// ----------------------------------------------------------------------------
// buf_fill_mem
// DEPTH x WIDTH storage with synchronous write, combinational read and a
// synchronous clear of every entry on rst.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high clear
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  entry at raddr_i (combinational)
// ----------------------------------------------------------------------------
module buf_fill_mem
   import buf_fill_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = WIDTH_DEF,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/buf_fill_ctrl.sv
// ----------------------------------------------------------------------------
// buf_fill_ctrl
// Fills a DEPTH-entry buffer from sample_in (one entry per enabled FILL
// cycle), then drains it through a valid/ready port and pulses done.
//
// Handshake: a drain transfer happens on every posedge where out_valid and
// out_ready are both high; out_valid never drops and out_data never changes
// while a transfer is pending.
//
// Optional feature: define BUF_FILL_CTRL_AUTO_RESTART_EN to go straight from
// the final drain transfer back to FILL (pointers at 0) instead of IDLE.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   start      in   fill request (IDLE only)
//   enable     in   fill qualifier (FILL only)
//   sample_in  in   sample written on an enabled FILL cycle
//   out_ready  in   downstream ready (DRAIN only)
//   out_valid  out  drain data valid
//   out_data   out  buffer entry at the read pointer
//   out_last   out  valid entry is DEPTH-1
//   busy       out  FILL or DRAIN
//   full       out  DRAIN
//   fill_cnt   out  entries written and not yet drained
//   done       out  one-cycle pulse after the final drain transfer
//   state_dbg  out  current FSM state
// ----------------------------------------------------------------------------
module buf_fill_ctrl
   import buf_fill_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   enable,
   input  logic [WIDTH-1:0]       sample_in,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_last,
   output logic                   busy,
   output logic                   full,
   output logic [$clog2(DEPTH):0] fill_cnt,
   output logic                   done,
   output state_e                 state_dbg
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   state_e         state_q, state_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           done_q, done_d;

   logic           wr_en;
   logic           xfer;
   logic           last_wr;
   logic           last_rd;

   assign wr_en   = (state_q == FILL) && enable;
   assign xfer    = (state_q == DRAIN) && out_ready;
   assign last_wr = (wr_ptr_q == AW'(DEPTH - 1));
   assign last_rd = (rd_ptr_q == AW'(DEPTH - 1));

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start) state_d = FILL;
         FILL:  if (wr_en && last_wr) state_d = DRAIN;
         DRAIN: begin
            if (xfer && last_rd) begin
`ifdef BUF_FILL_CTRL_AUTO_RESTART_EN
               state_d = FILL;
`else
               state_d = IDLE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      out_valid = 1'b0;
      out_last  = 1'b0;
      full      = 1'b0;
      busy      = 1'b0;
      case (state_q)
         FILL: busy = 1'b1;
         DRAIN: begin
            busy      = 1'b1;
            full      = 1'b1;
            out_valid = 1'b1;
            out_last  = last_rd;
         end
         default: ;
      endcase
   end

   assign fill_cnt  = cnt_q;
   assign done      = done_q;
   assign state_dbg = state_q;

   // ---------------- pointers, count, done ----------------
   // Pointers are exactly AW bits and DEPTH is a power of two, so the
   // increment past DEPTH-1 wraps to 0 on its own; after the final drain
   // both pointers are 0 and the count is 0, ready for the next fill.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               cnt_d    = '0;
            end
         end
         FILL: begin
            if (enable) begin
               wr_ptr_d = wr_ptr_q + AW'(1);
               cnt_d    = cnt_q + CW'(1);
            end
         end
         DRAIN: begin
            if (out_ready) begin
               rd_ptr_d = rd_ptr_q + AW'(1);
               cnt_d    = cnt_q - CW'(1);
               done_d   = last_rd;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
      end
   end

   // ---------------- storage ----------------
   buf_fill_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (sample_in),
      .raddr_i (rd_ptr_q),
      .rdata_o (out_data)
   );

endmodule
